reduce_nway: RTL

Parametrised, pipelined N-input single-bit reduction unit with run-time selectable operation (OR, AND, XOR, NOR) and an optional sticky accumulator across successive words. It generalises the fixed 8-input OR tree to any width from 2 to 64 inputs. It adds one register per tree level, a valid pipeline and a per-word mode. It feeds status/flag logic such as zero-detect, all-ones detect, parity and event aggregation, at one word per clock.

---
 rtl/reduce_pkg.sv | 25 ++
 rtl/reduce_stage.sv | 61 ++++++
 rtl/reduce_nway.sv | 88 ++++++++
 3 files changed

// File: rtl/reduce_pkg.sv
// Shared mode encoding and per-mode helpers for the N-way reduction tree.
// The base operation is the 2-input gate applied at every tree level and by the accumulator.
package reduce_pkg;

  typedef enum logic [1:0] {
    MODE_OR  = 2'b00,
    MODE_AND = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_e;

  // NOR shares OR's tree; its inversion is applied once at the root.
  function automatic logic base_op(input logic a, input logic b, input mode_e mode);
    case (mode)
      MODE_AND: return a & b;
      MODE_XOR: return a ^ b;
      default:  return a | b;
    endcase
  endfunction

  function automatic logic identity(input mode_e mode);
    return (mode == MODE_AND);
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: combines adjacent pairs with the word's base op and registers the result
// together with the word's mode, accumulate flag and valid bit.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter  int W_IN  = 2,
  localparam int W_OUT = (W_IN + 1) / 2
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [W_IN-1:0]  i_data,
  input  mode_e            i_mode,
  input  logic             i_acc_en,
  input  logic             i_valid,
  output logic [W_OUT-1:0] o_data,
  output mode_e            o_mode,
  output logic             o_acc_en,
  output logic             o_valid
);

  logic [W_OUT-1:0] w_comb;
  logic [W_OUT-1:0] r_data;
  mode_e            r_mode;
  logic             r_acc_en;
  logic             r_valid;

  // NOTE: every bit gets a default before the loop so no path leaves w_comb unassigned (no latch).
  always_comb begin
    w_comb = '0;
    for (int k = 0; k < W_IN / 2; k++) begin
      w_comb[k] = base_op(i_data[2*k], i_data[2*k+1], i_mode);
    end
    if (W_IN % 2 == 1) begin
      w_comb[W_OUT-1] = i_data[W_IN-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance on the same edge.
  // Payload only loads with a valid word, so idle cycles keep the last result stable.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_data   <= '0;
      r_mode   <= MODE_OR;
      r_acc_en <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data   <= w_comb;
        r_mode   <= i_mode;
        r_acc_en <= i_acc_en;
      end
    end
  end

  assign o_data   = r_data;
  assign o_mode   = r_mode;
  assign o_acc_en = r_acc_en;
  assign o_valid  = r_valid;

endmodule

// File: rtl/reduce_nway.sv
// Pipelined N-input single-bit reduction (OR/AND/XOR/NOR) with one register per tree level
// and a sticky accumulator fed by words as they leave the pipe.
module reduce_nway
  import reduce_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [N-1:0] i_in,
  input  logic         i_in_valid,
  input  logic [1:0]   i_mode,
  input  logic         i_acc_en,
  input  logic         i_acc_clear,
  output logic         o_out,
  output logic         o_out_valid,
  output logic         o_acc,
  output logic         o_acc_valid
);

  localparam int L      = $clog2(N);
  localparam int P      = 1 << L;
  localparam int TREE_W = 2 * P - 1;

  // All tree levels packed back to back: level s (width P>>s) starts at bit 2P - 2(P>>s).
  logic [TREE_W-1:0] w_tree;
  mode_e             w_mode   [0:L];
  logic              w_acc_en [0:L];
  logic              w_valid  [0:L];

  assign w_mode[0]   = mode_e'(i_mode);
  assign w_acc_en[0] = i_acc_en;
  assign w_valid[0]  = i_in_valid;

  for (genvar j = 0; j < P; j++) begin : gen_leaf
    if (j < N) begin : gen_real
      assign w_tree[j] = i_in[j];
    end else begin : gen_pad
      assign w_tree[j] = identity(w_mode[0]);
    end
  end

  for (genvar s = 0; s < L; s++) begin : gen_stage
    localparam int W       = P >> s;
    localparam int OFF_IN  = 2 * P - 2 * W;
    localparam int OFF_OUT = 2 * P - W;

    reduce_stage #(.W_IN(W)) u_stage (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_data   (w_tree[OFF_IN +: W]),
      .i_mode   (w_mode[s]),
      .i_acc_en (w_acc_en[s]),
      .i_valid  (w_valid[s]),
      .o_data   (w_tree[OFF_OUT +: W/2]),
      .o_mode   (w_mode[s+1]),
      .o_acc_en (w_acc_en[s+1]),
      .o_valid  (w_valid[s+1])
    );
  end

  logic w_out;
  logic r_acc;
  logic r_acc_valid;

  // NOR inversion sits after the last register; it depends only on registered state.
  assign w_out = w_tree[TREE_W-1] ^ (w_mode[L] == MODE_NOR);

  // A clear coinciding with an accumulating exit discards the old contents but keeps the new word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_acc       <= 1'b0;
      r_acc_valid <= 1'b0;
    end else if (w_valid[L] && w_acc_en[L]) begin
      r_acc       <= (i_acc_clear || !r_acc_valid) ? w_out : base_op(r_acc, w_out, w_mode[L]);
      r_acc_valid <= 1'b1;
    end else if (i_acc_clear) begin
      r_acc       <= 1'b0;
      r_acc_valid <= 1'b0;
    end
  end

  assign o_out       = w_out;
  assign o_out_valid = w_valid[L];
  assign o_acc       = r_acc;
  assign o_acc_valid = r_acc_valid;

endmodule
